perip_bus_arb: RTL and testbench

Two-requester, round-robin arbiter that shares one memory-mapped peripheral register port (timer-style: separate read/write address, read/write enables, registered read data) between the core load/store unit (requester 0) and a secondary master such as debug or DMA (requester 1). It accepts at most one transaction per cycle. It registers the winning command onto the peripheral port and routes the peripheral's one-cycle-latency read data back to the requester that issued the read.

---
 rtl/perip_bus_arb.sv | 95 +++++++++
 tb/tb_perip_bus_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perip_bus_arb.sv
// Two-requester round-robin arbiter sharing one registered peripheral register port.
// The winning command is registered onto the port; read data is routed back by a tag pipeline.
module perip_bus_arb #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [ADDR_W-1:0] s_r_addr_o,
    output logic [ADDR_W-1:0] s_w_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    output logic              s_r_enable_o,
    output logic              s_w_enable_o,
    input  logic [DATA_W-1:0] s_data_i
);

    logic              last;
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_tag_v;
    logic              rd_tag_id;
    logic              rvalid0;
    logic              rvalid1;

    // Contention goes to the requester that was not granted most recently.
    always_comb begin
        gnt0      = m0_req_i & (~m1_req_i | last);
        gnt1      = m1_req_i & (~m0_req_i | ~last);
        any_gnt   = gnt0 | gnt1;
        sel_we    = gnt1 ? m1_we_i    : m0_we_i;
        sel_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
        sel_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last         <= 1'b1;
            s_r_addr_o   <= '0;
            s_w_addr_o   <= '0;
            s_data_o     <= '0;
            s_r_enable_o <= 1'b0;
            s_w_enable_o <= 1'b0;
            rd_tag_v     <= 1'b0;
            rd_tag_id    <= 1'b0;
            rvalid0      <= 1'b0;
            rvalid1      <= 1'b0;
        end else begin
            s_r_enable_o <= 1'b0;
            s_w_enable_o <= 1'b0;
            rd_tag_v     <= 1'b0;
            if (any_gnt) begin
                last      <= gnt1;
                rd_tag_v  <= ~sel_we;
                rd_tag_id <= gnt1;
                if (sel_we) begin
                    s_w_addr_o   <= sel_addr;
                    s_data_o     <= sel_wdata;
                    s_w_enable_o <= 1'b1;
                end else begin
                    s_r_addr_o   <= sel_addr;
                    s_r_enable_o <= 1'b1;
                end
            end
            // Tag moves alongside the read strobe; rvalid lines up with s_data_i.
            rvalid0 <= rd_tag_v & ~rd_tag_id;
            rvalid1 <= rd_tag_v & rd_tag_id;
        end
    end

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign m0_rvalid_o = rvalid0;
    assign m1_rvalid_o = rvalid1;
    assign m0_rdata_o  = rvalid0 ? s_data_i : '0;
    assign m1_rdata_o  = rvalid1 ? s_data_i : '0;

endmodule

// File: tb/tb_perip_bus_arb.sv
// Directed bench for perip_bus_arb with a small registered peripheral register file.
module tb_perip_bus_arb;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] s_r_addr, s_w_addr, s_data_o, s_data_i;
    logic        s_r_enable, s_w_enable;
    logic        poke;
    logic [31:0] poke_val;
    logic [31:0] regs [4];

    int assertions;
    int failures;

    perip_bus_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .s_r_addr_o(s_r_addr), .s_w_addr_o(s_w_addr), .s_data_o(s_data_o),
        .s_r_enable_o(s_r_enable), .s_w_enable_o(s_w_enable), .s_data_i(s_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral: write on strobe edge, read data registered one cycle after read strobe.
    always @(posedge clk) begin
        if (!rst_n) begin
            regs[0]  <= 32'h0000_0011;
            regs[1]  <= 32'h0000_00AB;
            regs[2]  <= 32'h0;
            regs[3]  <= 32'h0;
            s_data_i <= 32'h0;
        end else begin
            if (s_w_enable) regs[s_w_addr[3:2]] <= s_data_o;
            if (poke) regs[1] <= poke_val;
            if (s_r_enable) s_data_i <= regs[s_r_addr[3:2]];
        end
    end

    task automatic idle();
        m0_req = 0; m1_req = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; poke = 0; poke_val = 0;
        m0_req = 1; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 1; m1_we = 0; m1_addr = 4; m1_wdata = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            assertions++;
            if ({s_r_enable, s_w_enable, m0_rvalid, m1_rvalid} !== 4'b0) begin
                failures++;
                $display("FAIL reset_strobes cycle %0d: got %b expected 0000", i,
                         {s_r_enable, s_w_enable, m0_rvalid, m1_rvalid});
            end
            assertions++;
            if (s_r_addr !== 32'h0 || s_w_addr !== 32'h0 || s_data_o !== 32'h0) begin
                failures++;
                $display("FAIL reset_regs: r_addr=%h w_addr=%h data=%h expected 0", s_r_addr, s_w_addr, s_data_o);
            end
        end
        rst_n = 1;
        #1;
        assertions++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL reset_first_contention: gnt=%b expected 10", {m0_gnt, m1_gnt});
        end
        idle();
    endtask

    task automatic test_contention();
        m0_we = 0; m0_addr = 32'h0;
        m1_we = 1; m1_addr = 32'h4; m1_wdata = 32'h55;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            m0_req = (i < 4); m1_req = (i < 4);
            #1;
            if (i < 4) begin
                assertions++;
                if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL contention_gnt cycle %0d: got %b expected %b", i,
                             {m0_gnt, m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
                end
            end
            if (i >= 1 && i <= 4) begin
                assertions++;
                if ({s_r_enable, s_w_enable} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL contention_strobe cycle %0d: got %b", i, {s_r_enable, s_w_enable});
                end
                if ((i - 1) % 2 == 1) begin
                    assertions++;
                    if (s_w_addr !== 32'h4 || s_data_o !== 32'h55) begin
                        failures++;
                        $display("FAIL contention_write: addr=%h data=%h expected 4/55", s_w_addr, s_data_o);
                    end
                end
            end
            if (i >= 2) begin
                assertions++;
                if (m0_rvalid !== ((i - 2) % 2 == 0) || m1_rvalid !== 1'b0 ||
                    (m0_rvalid === 1'b1 && m0_rdata !== 32'h11)) begin
                    failures++;
                    $display("FAIL contention_rvalid cycle %0d: m0_rv=%b m0_rd=%h m1_rv=%b", i,
                             m0_rvalid, m0_rdata, m1_rvalid);
                end
            end
        end
        idle();
    endtask

    task automatic test_lone_read();
        poke = 1; poke_val = 32'h0000_00AB;
        @(negedge clk);
        poke = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h4;
        #1;
        assertions++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL lone_gnt: got %b expected 10", {m0_gnt, m1_gnt});
        end
        @(negedge clk);
        idle();
        assertions++;
        if (s_r_enable !== 1'b1 || s_w_enable !== 1'b0 || s_r_addr !== 32'h4 || m0_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL lone_strobe: r_en=%b w_en=%b r_addr=%h rv=%b", s_r_enable, s_w_enable, s_r_addr, m0_rvalid);
        end
        @(negedge clk);
        assertions++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hAB || m1_rvalid !== 1'b0 || m1_rdata !== 32'h0 ||
            s_r_enable !== 1'b0) begin
            failures++;
            $display("FAIL lone_resp: m0_rv=%b m0_rd=%h m1_rv=%b m1_rd=%h expected 1/ab/0/0",
                     m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exp [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h0;
        exp[0] = 32'h11; exp[1] = 32'hAB; exp[2] = 32'h11;
        m1_we = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            m1_req = (i < 3);
            if (i < 3) m1_addr = addrs[i];
            #1;
            if (i < 3) begin
                assertions++;
                if ({m0_gnt, m1_gnt} !== 2'b01) begin
                    failures++;
                    $display("FAIL b2b_gnt cycle %0d: got %b expected 01", i, {m0_gnt, m1_gnt});
                end
            end
            if (i >= 2 && i < 5) begin
                assertions++;
                if (m1_rvalid !== 1'b1 || m1_rdata !== exp[i - 2] || m0_rvalid !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_resp %0d: m1_rv=%b m1_rd=%h expected 1/%h", i - 2, m1_rvalid, m1_rdata, exp[i - 2]);
                end
            end
            if (i == 5) begin
                assertions++;
                if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
                    failures++;
                    $display("FAIL b2b_tail: m1_rv=%b m1_rd=%h expected 0/0", m1_rvalid, m1_rdata);
                end
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m0_req = (i < 2); m0_we = (i == 0); m0_addr = 32'h4; m0_wdata = 32'h1234_5678;
            #1;
            if (i < 2) begin
                assertions++;
                if ({m0_gnt, m1_gnt} !== 2'b10) begin
                    failures++;
                    $display("FAIL wr_gnt cycle %0d: got %b expected 10", i, {m0_gnt, m1_gnt});
                end
            end
            if (i == 1) begin
                assertions++;
                if (s_w_enable !== 1'b1 || s_r_enable !== 1'b0 || s_w_addr !== 32'h4 || s_data_o !== 32'h1234_5678) begin
                    failures++;
                    $display("FAIL wr_write_strobe: w_en=%b r_en=%b addr=%h data=%h", s_w_enable, s_r_enable, s_w_addr, s_data_o);
                end
            end
            if (i == 2) begin
                assertions++;
                if (s_r_enable !== 1'b1 || s_w_enable !== 1'b0 || s_r_addr !== 32'h4) begin
                    failures++;
                    $display("FAIL wr_read_strobe: r_en=%b w_en=%b addr=%h", s_r_enable, s_w_enable, s_r_addr);
                end
            end
            if (i == 3) begin
                assertions++;
                if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1234_5678) begin
                    failures++;
                    $display("FAIL wr_readback: rv=%b rd=%h expected 1/12345678", m0_rvalid, m0_rdata);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        m1_req = 1; m1_we = 0; m1_addr = 32'h0;
        #1;
        assertions++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            failures++;
            $display("FAIL rst_mid_gnt: got %b expected 01", {m0_gnt, m1_gnt});
        end
        @(negedge clk);
        idle();
        rst_n = 0;
        assertions++;
        if (s_r_enable !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_issue: r_en=%b expected 1", s_r_enable);
        end
        @(negedge clk);
        assertions++;
        if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0 || s_r_enable !== 1'b0 || s_r_addr !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_resp: m1_rv=%b m0_rv=%b r_en=%b r_addr=%h expected 0", m1_rvalid, m0_rvalid, s_r_enable, s_r_addr);
        end
        rst_n = 1;
        m0_req = 1; m0_we = 0; m1_req = 1;
        #1;
        assertions++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL rst_mid_contention: gnt=%b expected 10", {m0_gnt, m1_gnt});
        end
        idle();
        @(negedge clk);
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        test_reset();
        test_contention();
        test_lone_read();
        test_back_to_back();
        test_write_read();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
